// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding and default parameters for the TRNG health monitor
package trng_pkg;
   typedef enum logic [1:0] {
      ST_STARTUP = 2'b00,
      ST_RUN     = 2'b01,
      ST_FAIL    = 2'b10
   } state_t;
   localparam int DEF_WIDTH           = 8;
   localparam int DEF_RCT_CUTOFF      = 4;
   localparam int DEF_APT_WINDOW      = 512;
   localparam int DEF_APT_CUTOFF      = 13;
   localparam int DEF_STARTUP_SAMPLES = 1024;
endpackage

// File: rtl/trng_apt_window.sv
// trng_apt_window: adaptive proportion test over fixed windows, flags the sample that reaches the cutoff
module trng_apt_window import trng_pkg::*; #(
   parameter int WIDTH      = DEF_WIDTH,
   parameter int APT_WINDOW = DEF_APT_WINDOW,
   parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sync_clear,
   input  logic             en,
   input  logic [WIDTH-1:0] sample,
   output logic             apt_hit_fail
);
   localparam int IW = $clog2(APT_WINDOW);
   localparam int CW = $clog2(APT_CUTOFF + 1);
   logic [IW-1:0]    idx;
   logic [CW-1:0]    acnt, acnt_nxt;
   logic [WIDTH-1:0] ref_val;
   assign acnt_nxt = idx == '0 ? CW'(1) :
                     (sample == ref_val && acnt != CW'(APT_CUTOFF)) ? acnt + 1'b1 : acnt;
   assign apt_hit_fail = en && acnt_nxt == CW'(APT_CUTOFF);
   // power-of-two window: the index wraps naturally after the last sample
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idx     <= '0;
         acnt    <= '0;
         ref_val <= '0;
      end else if (sync_clear) begin
         idx     <= '0;
         acnt    <= '0;
         ref_val <= '0;
      end else if (en) begin
         if (idx == '0) ref_val <= sample;
         acnt <= acnt_nxt;
         idx  <= idx + 1'b1;
      end
   end
endmodule

// File: rtl/trng_health_monitor.sv
// trng_health_monitor: RCT/APT health tests with startup gating, sticky alarms and filtered forwarding
module trng_health_monitor import trng_pkg::*; #(
   parameter int WIDTH           = DEF_WIDTH,
   parameter int RCT_CUTOFF      = DEF_RCT_CUTOFF,
   parameter int APT_WINDOW      = DEF_APT_WINDOW,
   parameter int APT_CUTOFF      = DEF_APT_CUTOFF,
   parameter int STARTUP_SAMPLES = DEF_STARTUP_SAMPLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] sample_in,
   input  logic             sample_valid,
   input  logic             clear_fail,
   output logic [WIDTH-1:0] ent_data,
   output logic             ent_valid,
   output logic             healthy,
   output logic             rct_fail,
   output logic             apt_fail,
   output logic [1:0]       state
);
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   localparam int SW = $clog2(STARTUP_SAMPLES + 1);
   state_t           st, st_nxt;
   logic [WIDTH-1:0] last;
   logic             have_last;
   logic [RW-1:0]    rcnt, rcnt_nxt;
   logic [SW-1:0]    scnt;
   logic             acc, clr, rct_hit, apt_hit, hit, fwd;
   assign acc      = sample_valid && st != ST_FAIL;
   assign clr      = clear_fail && st == ST_FAIL;
   assign rcnt_nxt = (have_last && sample_in == last) ?
                     (rcnt == RW'(RCT_CUTOFF) ? rcnt : rcnt + 1'b1) : RW'(1);
   assign rct_hit  = acc && rcnt_nxt == RW'(RCT_CUTOFF);
   assign hit      = rct_hit || apt_hit;
   assign fwd      = acc && !hit && st == ST_RUN;
   assign healthy  = st == ST_RUN;
   assign state    = st;
   trng_apt_window #(
      .WIDTH      (WIDTH),
      .APT_WINDOW (APT_WINDOW),
      .APT_CUTOFF (APT_CUTOFF)
   ) u_apt (
      .clk          (clk),
      .reset        (reset),
      .sync_clear   (clr),
      .en           (acc),
      .sample       (sample_in),
      .apt_hit_fail (apt_hit)
   );
   always_comb begin
      st_nxt = clr ? ST_STARTUP :
               !acc ? st :
               hit ? ST_FAIL :
               (st == ST_STARTUP && scnt == SW'(STARTUP_SAMPLES - 1)) ? ST_RUN : st;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) st <= ST_STARTUP;
      else st <= st_nxt;
   end
   // in FAIL nothing is accepted, so every test register stays frozen until clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_data  <= '0;
         ent_valid <= 1'b0;
         rct_fail  <= 1'b0;
         apt_fail  <= 1'b0;
         last      <= '0;
         have_last <= 1'b0;
         rcnt      <= '0;
         scnt      <= '0;
      end else begin
         ent_valid <= fwd;
         if (fwd) ent_data <= sample_in;
         if (clr) begin
            rct_fail  <= 1'b0;
            apt_fail  <= 1'b0;
            have_last <= 1'b0;
            rcnt      <= '0;
            scnt      <= '0;
         end else if (acc) begin
            rct_fail  <= rct_fail | rct_hit;
            apt_fail  <= apt_fail | apt_hit;
            have_last <= 1'b1;
            last      <= sample_in;
            rcnt      <= rcnt_nxt;
            if (st == ST_STARTUP) scnt <= scnt + 1'b1;
         end
      end
   end
endmodule

// File: doc/trng_health_monitor.md
Name: trng_health_monitor

Overview:
- Consumer end of the TRNG output stream: takes raw samples from the entropy source, runs continuous health tests (Repetition Count Test and Adaptive Proportion Test), and forwards only samples that pass to downstream logic.
- Runs a startup test before any data is forwarded.
- Latches a sticky alarm on failure and holds it until software clears it.

Parameters:
- WIDTH, 8, sample width in bits
- RCT_CUTOFF, 4, number of identical consecutive samples that declares an RCT failure
- APT_WINDOW, 512, APT window length in samples (power of two)
- APT_CUTOFF, 13, occurrences of the window reference value within one window that declare an APT failure
- STARTUP_SAMPLES, 1024, number of passing samples required before entering RUN

Ports:
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high reset
- sample_in  in  WIDTH  raw TRNG sample
- sample_valid  in  1  sample_in is valid this cycle (single-cycle strobe, no backpressure)
- clear_fail  in  1  pulse; leaves FAIL and restarts the startup test
- ent_data  out  WIDTH  forwarded sample that passed the tests
- ent_valid  out  1  ent_data is valid (1-cycle pulse)
- healthy  out  1  high only in RUN
- rct_fail  out  1  sticky RCT failure flag
- apt_fail  out  1  sticky APT failure flag
- state  out  2  00 = STARTUP, 01 = RUN, 10 = FAIL

Behaviour:
- Reset (asynchronous) values:
  - state = STARTUP; all outputs 0.
  - All counters 0; RCT "have last" flag 0; APT window index 0.
- Evaluation:
  - Tests evaluate each sample on the cycle sample_valid is high.
  - Registered results appear on the next edge, giving 1-cycle latency from sample to ent_valid/flags.
- RCT:
  - First sample after reset or clear: last = sample, rcnt = 1.
  - Then, if sample == last: rcnt++ (saturating at RCT_CUTOFF). Otherwise: last = sample, rcnt = 1.
  - Failure when the updated rcnt == RCT_CUTOFF.
- APT:
  - At window index 0: ref = sample, acnt = 1, idx = 1.
  - Otherwise: idx++, and acnt++ if sample == ref (saturating at APT_CUTOFF).
  - Failure when the updated acnt == APT_CUTOFF.
  - After the APT_WINDOW-th sample, idx wraps to 0, so the next sample starts a new window.
  - Windows run continuously across STARTUP→RUN with no realignment.
- A failing sample is never forwarded. If both tests fail on the same sample, both flags are set.
- STARTUP:
  - Samples are not forwarded; a sample counter counts samples.
  - On any failure: → FAIL.
  - When the counter reaches STARTUP_SAMPLES with no failure: → RUN. healthy rises on the edge after the last startup sample is registered.
- RUN:
  - Each passing sample gives ent_valid = 1 and ent_data = sample on the next cycle.
  - On failure: → FAIL; ent_valid stays 0 for that sample.
- FAIL:
  - ent_valid = 0, healthy = 0.
  - Flags are held.
  - Samples are ignored and counters are frozen.
- clear_fail:
  - In FAIL: → STARTUP on the next edge. Clears flags, all test counters, the RCT "have last" flag, the window index and the startup counter.
  - If clear_fail and sample_valid are asserted together in FAIL, the clear wins and the sample is dropped.
  - clear_fail is ignored in STARTUP and RUN.
- ent_valid is never high in any state other than RUN.
- Asynchronous reset mid-operation: the state returns to STARTUP immediately and ent_valid drops asynchronously.

Decomposition:
- Shared package trng_pkg:
  - State encoding constants (ST_STARTUP, ST_RUN, ST_FAIL).
  - Default cutoff and window constants.
  - WIDTH default of 8 (matches the TRNG rand_out width).
- One sub-module, trng_apt_window: holds the APT ref, count and index, and outputs apt_hit_fail. It is cleared by a sync_clear input.
- RCT and the FSM live in the top module.

Test Plan:
- Startup pass: after reset, drive 1024 samples of value (i mod 256), one per cycle → ent_valid stays 0; state = 01 and healthy = 1 exactly one cycle after the 1024th sample; sample 1025 appears on ent_data one cycle later.
- RCT failure in RUN: after startup, drive 0xA5 four times → the first three are forwarded; the fourth is not; rct_fail = 1, apt_fail = 0, state = 10 one cycle after the fourth.
- APT failure: after startup (window aligned), alternate 0x3C with distinct values 0x00, 0x01, ... → the 13th 0x3C (window sample 25) sets apt_fail = 1; samples 1–24 are forwarded; sample 25 is not.
- APT wrap: in RUN, drive 512 samples containing twelve 0x3C as the window reference, then a new window with twelve more → no failure; healthy stays 1.
- Clear/restart: in FAIL, pulse clear_fail together with sample_valid → the sample is dropped; next cycle state = 00 and flags = 0; a further 1024 good samples are needed before healthy = 1.
- Reset mid-operation: in RUN with a sample in flight, assert reset between clock edges → ent_valid, healthy and flags go 0 immediately; state = 00.
